// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if
//   Connects the control unit to the MAR/MDR memory-access sequencer.
//   It carries the two request/done handshakes (instruction fetch and
//   load/store) and the datapath control strobes driven by the sequencer.
//
//   master modport : requester side. Drives if_req, ls_req and ls_we.
//                    Receives the datapath strobes and the done pulses.
//   slave modport  : sequencer side. The directions are the reverse of master.
//
//   Signals
//     if_req    IF read request, level, held until if_done
//     ls_req    LS request, level, held until ls_done
//     ls_we     LS direction (1 = write), sampled at grant
//     bus_sel   bus source: 00 none, 01 IF addr, 10 LS addr, 11 LS wdata
//     MARin     MAR load strobe
//     MDRin     MDR load strobe
//     Read      MDR input select (1 = Mdatain, 0 = BusMuxOut)
//     MDRout    MDR drives the bus (read result)
//     mem_read  memory read strobe
//     mem_write memory write strobe
//     if_done   1-cycle IF completion pulse
//     ls_done   1-cycle LS completion pulse
//     busy      sequencer is not idle
interface mem_access_sequencer_if;
  logic       if_req;
  logic       ls_req;
  logic       ls_we;
  logic [1:0] bus_sel;
  logic       MARin;
  logic       MDRin;
  logic       Read;
  logic       MDRout;
  logic       mem_read;
  logic       mem_write;
  logic       if_done;
  logic       ls_done;
  logic       busy;

  modport master (
    output if_req, ls_req, ls_we,
    input  bus_sel, MARin, MDRin, Read, MDRout,
           mem_read, mem_write, if_done, ls_done, busy
  );

  modport slave (
    input  if_req, ls_req, ls_we,
    output bus_sel, MARin, MDRin, Read, MDRout,
           mem_read, mem_write, if_done, ls_done, busy
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Sequences one memory access at a time through the MAR/MDR datapath for
//   two requesters: instruction fetch (IF, always a read) and load/store (LS,
//   read or write). The arbiter runs only in IDLE. When both requesters are
//   pending, the grant alternates between them. An access then moves through
//   ADDR -> [WDATA] -> WAIT -> [CAPTURE] -> DONE and returns to IDLE.
//
//   Ports
//     clock  rising-edge system clock
//     clear  asynchronous active-high reset
//     bus    mem_access_sequencer_if.slave (requests in, strobes/done out)
//
//   Parameters
//     WAIT_STATES  cycles spent in WAIT, legal range 1..15
module mem_access_sequencer #(
  parameter int WAIT_STATES = 2
) (
  input  logic                         clock,
  input  logic                         clear,
  mem_access_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDATA   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Owner / last-grant encoding: 0 = IF, 1 = LS.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  // WAIT is entered with the counter preloaded so that it exits after
  // exactly WAIT_STATES cycles, when the counter reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       is_wr_q, is_wr_d;
  logic       last_grant_q, last_grant_d;

  logic       ls_wins;

  logic [1:0] bus_sel;
  logic       mar_in;
  logic       mdr_in;
  logic       read_sel;
  logic       mdr_out;
  logic       mem_read;
  logic       mem_write;
  logic       if_done;
  logic       ls_done;
  logic       busy;

  // State and access-context registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWNER_IF;
      is_wr_q      <= 1'b0;
      last_grant_q <= OWNER_IF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      is_wr_q      <= is_wr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // LS wins when it is the only requester. It also wins under contention
  // when IF had the previous grant. last_grant resets to IF, so the first
  // contention after reset goes to LS.
  always_comb begin
    ls_wins = bus.ls_req && (!bus.if_req || (last_grant_q == OWNER_IF));
  end

  // Next-state logic. Requests are looked at only in IDLE. A request that
  // drops mid-access does not abort the access.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    is_wr_d      = is_wr_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          state_d      = ST_ADDR;
          owner_d      = ls_wins;
          last_grant_d = ls_wins;
          is_wr_d      = bus.ls_we & ls_wins;
        end
      end

      ST_ADDR: begin
        if (is_wr_q) begin
          state_d = ST_WDATA;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end

      ST_WDATA: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_INIT;
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = is_wr_q ? ST_DONE : ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode. It uses only registered state, so no input
  // reaches an output combinationally. mem_read and mem_write come from
  // is_wr and its complement, so they can never be high together.
  always_comb begin
    bus_sel   = 2'b00;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    read_sel  = 1'b0;
    mdr_out   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_done   = 1'b0;
    ls_done   = 1'b0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_ADDR: begin
        mar_in  = 1'b1;
        bus_sel = (owner_q == OWNER_LS) ? 2'b10 : 2'b01;
      end

      ST_WDATA: begin
        bus_sel  = 2'b11;
        mdr_in   = 1'b1;
        read_sel = 1'b0;
      end

      ST_WAIT: begin
        mem_write = is_wr_q;
        mem_read  = ~is_wr_q;
      end

      ST_CAPTURE: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        read_sel = 1'b1;
      end

      ST_DONE: begin
        mdr_out = ~is_wr_q;
        if_done = (owner_q == OWNER_IF);
        ls_done = (owner_q == OWNER_LS);
      end

      default: begin
      end
    endcase
  end

  assign bus.bus_sel   = bus_sel;
  assign bus.MARin     = mar_in;
  assign bus.MDRin     = mdr_in;
  assign bus.Read      = read_sel;
  assign bus.MDRout    = mdr_out;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.if_done   = if_done;
  assign bus.ls_done   = ls_done;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer
//   Directed bench for mem_access_sequencer. The bench has two instances:
//   dut_a with WAIT_STATES=2 and dut_b with WAIT_STATES=1.
//   Output vectors are packed as
//     {bus_sel[1:0], MARin, MDRin, Read, MDRout, mem_read, mem_write,
//      if_done, ls_done, busy}
//   and compared against hand-computed constants cycle by cycle.
//   The bench drives inputs and samples outputs on the falling edge.
module tb_mem_access_sequencer;

  localparam logic [10:0] V_IDLE       = 11'b00_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] V_ADDR_IF    = 11'b01_1_0_0_0_0_0_0_0_1;
  localparam logic [10:0] V_ADDR_LS    = 11'b10_1_0_0_0_0_0_0_0_1;
  localparam logic [10:0] V_WDATA      = 11'b11_0_1_0_0_0_0_0_0_1;
  localparam logic [10:0] V_WAIT_RD    = 11'b00_0_0_0_0_1_0_0_0_1;
  localparam logic [10:0] V_WAIT_WR    = 11'b00_0_0_0_0_0_1_0_0_1;
  localparam logic [10:0] V_CAPT       = 11'b00_0_1_1_0_1_0_0_0_1;
  localparam logic [10:0] V_DONE_IF_RD = 11'b00_0_0_0_1_0_0_1_0_1;
  localparam logic [10:0] V_DONE_LS_RD = 11'b00_0_0_0_1_0_0_0_1_1;
  localparam logic [10:0] V_DONE_LS_WR = 11'b00_0_0_0_0_0_0_0_1_1;

  logic clock;
  logic clear;

  int vectors_applied = 0;
  int miscompares     = 0;

  mem_access_sequencer_if if_a ();
  mem_access_sequencer_if if_b ();

  mem_access_sequencer #(.WAIT_STATES(2)) dut_a (
    .clock (clock),
    .clear (clear),
    .bus   (if_a.slave)
  );

  mem_access_sequencer #(.WAIT_STATES(1)) dut_b (
    .clock (clock),
    .clear (clear),
    .bus   (if_b.slave)
  );

  logic [10:0] outs_a;
  logic [10:0] outs_b;

  assign outs_a = {if_a.bus_sel, if_a.MARin, if_a.MDRin, if_a.Read, if_a.MDRout,
                   if_a.mem_read, if_a.mem_write, if_a.if_done, if_a.ls_done, if_a.busy};
  assign outs_b = {if_b.bus_sel, if_b.MARin, if_b.MDRin, if_b.Read, if_b.MDRout,
                   if_b.mem_read, if_b.mem_write, if_b.if_done, if_b.ls_done, if_b.busy};

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    vectors_applied++;
    if (got !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  // Drives the request inputs of one instance (sel_b = 0 for dut_a, 1 for dut_b).
  task automatic applyStimulus(input logic sel_b, input logic ifr, input logic lsr, input logic we);
    if (sel_b) begin
      if_b.if_req = ifr;
      if_b.ls_req = lsr;
      if_b.ls_we  = we;
    end else begin
      if_a.if_req = ifr;
      if_a.ls_req = lsr;
      if_a.ls_we  = we;
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Scoreboard: on every cycle, the read and write strobes must not be high together in either instance.
  always @(negedge clock) begin
    checkOutput("rw_excl_a", {31'd0, if_a.mem_read & if_a.mem_write}, 32'd0);
    checkOutput("rw_excl_b", {31'd0, if_b.mem_read & if_b.mem_write}, 32'd0);
  end

  logic [10:0] exp_if_rd [6] = '{V_ADDR_IF, V_WAIT_RD, V_WAIT_RD, V_CAPT, V_DONE_IF_RD, V_IDLE};
  logic [10:0] exp_ls_wr [6] = '{V_ADDR_LS, V_WDATA, V_WAIT_WR, V_WAIT_WR, V_DONE_LS_WR, V_IDLE};
  logic [10:0] exp_drop  [7] = '{V_ADDR_LS, V_WAIT_RD, V_WAIT_RD, V_CAPT, V_DONE_LS_RD, V_IDLE, V_IDLE};
  logic [10:0] exp_ws1   [5] = '{V_ADDR_IF, V_WAIT_RD, V_CAPT, V_DONE_IF_RD, V_IDLE};

  // Main directed sequence.
  initial begin
    logic [1:0] exp_done;
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("reset_a", {21'd0, outs_a}, {21'd0, V_IDLE});
    checkOutput("reset_b", {21'd0, outs_b}, {21'd0, V_IDLE});
    clear = 1'b0;
    @(negedge clock);
    checkOutput("idle_a", {21'd0, outs_a}, {21'd0, V_IDLE});

    // IF read with WAIT_STATES=2: done at cycle 5, idle at cycle 6.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      checkOutput($sformatf("if_rd_c%0d", i), {21'd0, outs_a}, {21'd0, exp_if_rd[i-1]});
      if (i == 5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // LS write. ls_we flips after the grant and must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      checkOutput($sformatf("ls_wr_c%0d", i), {21'd0, outs_a}, {21'd0, exp_ls_wr[i-1]});
      if (i == 1) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // clear asserted during WAIT aborts the access. The held if_req restarts at ADDR.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    checkOutput("clr_pre_wait", {21'd0, outs_a}, {21'd0, V_WAIT_RD});
    clear = 1'b1;
    #1;
    checkOutput("clr_async", {21'd0, outs_a}, {21'd0, V_IDLE});
    @(negedge clock);
    checkOutput("clr_hold", {21'd0, outs_a}, {21'd0, V_IDLE});
    clear = 1'b0;
    step();
    checkOutput("clr_restart", {21'd0, outs_a}, {21'd0, V_ADDR_IF});
    repeat (4) step();
    checkOutput("clr_done", {21'd0, outs_a}, {21'd0, V_DONE_IF_RD});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("clr_idle", {21'd0, outs_a}, {21'd0, V_IDLE});

    // Contention after reset: grants alternate LS, IF, LS, IF and done pulses come 6 cycles apart.
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      step();
      exp_done = (c == 5 || c == 17) ? 2'b01 : (c == 11 || c == 23) ? 2'b10 : 2'b00;
      checkOutput($sformatf("cont_done_c%0d", c), {30'd0, if_a.if_done, if_a.ls_done}, {30'd0, exp_done});
      if (c == 1 || c == 13) checkOutput($sformatf("cont_grant_c%0d", c), {21'd0, outs_a}, {21'd0, V_ADDR_LS});
      if (c == 7 || c == 19) checkOutput($sformatf("cont_grant_c%0d", c), {21'd0, outs_a}, {21'd0, V_ADDR_IF});
      if (c == 23) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (c == 24) checkOutput("cont_idle", {31'd0, if_a.busy}, 32'd0);
    end

    // ls_req drops in WAIT. The access still completes, and no new grant follows.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step();
      checkOutput($sformatf("drop_c%0d", i), {21'd0, outs_a}, {21'd0, exp_drop[i-1]});
      if (i == 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // WAIT_STATES=1 instance: an IF read gives if_done at cycle 4.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      checkOutput($sformatf("ws1_c%0d", i), {21'd0, outs_b}, {21'd0, exp_ws1[i-1]});
      if (i == 4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
